// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared CPU defines for pipeline control (stall vectors, FSM encodings, exception constants)
package pipe_ctrl_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_IF = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h00000020;
  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000E;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with exception redirect FSM and saturating stall counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        clr_cnt,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy,
  output logic [15:0] stall_cnt
);
  logic [1:0]  state, state_nx;
  logic [31:0] target;
  logic        exc_req, accept;
  assign exc_req = |excepttype_i;
  assign accept  = (state == ST_IDLE) && exc_req;
  assign flush   = state == ST_FLUSH;
  assign new_pc  = flush ? target : 32'd0;
  assign busy    = state != ST_IDLE;
  always_comb begin
    state_nx = state == ST_IDLE   ? (exc_req ? (stallreq_if ? ST_WAIT_IF : ST_FLUSH) : ST_IDLE)
             : state == ST_WAIT_IF ? (stallreq_if ? ST_WAIT_IF : ST_FLUSH)
             : ST_IDLE;
    // exception acceptance outranks every stall request, including MEM
    stall = rst                  ? STALL_NONE
          : state == ST_WAIT_IF ? STALL_ALL
          : state == ST_FLUSH   ? STALL_NONE
          : exc_req             ? STALL_ALL
          : stallreq_mem        ? STALL_MEM
          : stallreq_ex         ? STALL_EX
          : stallreq_id         ? STALL_ID
          : stallreq_if         ? STALL_IF
          : STALL_NONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= 32'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nx;
      if (accept) target <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
      stall_cnt <= clr_cnt ? 16'd0
                 : (|stall && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1
                 : stall_cnt;
    end
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clock and reset as: clk  in  1  single clock, rising-edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: stallreq_if  in  1  I-cache miss, fetch not complete.
REQ-003 SHALL have: stallreq_id  in  1  load-use hazard in ID.
REQ-004 SHALL have: stallreq_ex  in  1  multi-cycle EX op (madd/msub/div) in progress.
REQ-005 SHALL have: stallreq_mem  in  1  D-cache miss in MEM.
REQ-006 SHALL have: excepttype_i  in  32  MEM-stage exception code; 0 = none.
REQ-007 SHALL have: cp0_epc_i  in  32  current CP0 EPC.
REQ-008 SHALL have: clr_cnt  in  1  synchronous clear of stall counter.
REQ-009 SHALL have: stall  out  6  per-stage hold; bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
REQ-010 SHALL have: flush  out  1  clears all pipeline registers.
REQ-011 SHALL have: new_pc  out  32  redirect target, valid while flush=1.
REQ-012 SHALL have: busy  out  1  exception sequence in progress (state != IDLE).
REQ-013 SHALL have: stall_cnt  out  16  saturating count of stalled cycles.
REQ-014 SHALL have parameters: EXC_VECTOR, default 32'h00000020, general exception entry; ERET_CODE, default 32'h0000000E, excepttype value for eret.

Function
REQ-015 SHALL implement FSM with states IDLE, WAIT_IF, FLUSH; state is registered.
REQ-016 IDLE, excepttype_i!=0, stallreq_if=0 -> FLUSH next cycle; stallreq_if=1 -> WAIT_IF.
REQ-017 On the IDLE cycle accepting an exception, stall SHALL be 6'b111111 and target SHALL be latched: cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
REQ-018 WAIT_IF: stall=6'b111111, flush=0; on stallreq_if=0 -> FLUSH.
REQ-019 FLUSH: flush=1, new_pc=latched target, stall=6'b000000 for exactly one cycle, then IDLE.
REQ-020 excepttype_i SHALL be ignored in WAIT_IF and FLUSH; target SHALL NOT change after latching.
REQ-021 flush and new_pc SHALL be Moore outputs (function of state/registers only); new_pc=0 when flush=0.
REQ-022 IDLE, no exception: stall SHALL be the highest-priority request, combinational from inputs:
- stallreq_mem -> 6'b011111
- else stallreq_ex -> 6'b001111
- else stallreq_id -> 6'b000111
- else stallreq_if -> 6'b000011
- else 6'b000000
REQ-023 Exception in IDLE SHALL take priority over all stall requests, including simultaneous stallreq_mem.
REQ-024 stall_cnt SHALL increment by 1 on each cycle with stall!=0, saturate at 16'hFFFF, and clear to 0 on clr_cnt=1 (clear wins over increment).
REQ-025 busy SHALL be 1 in WAIT_IF and FLUSH, 0 in IDLE.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, target=0, stall_cnt=0; hence flush=0, new_pc=0, busy=0.
REQ-027 While rst=1, stall SHALL be 6'b000000 regardless of requests.
REQ-028 rst asserted in WAIT_IF or FLUSH SHALL abandon the sequence; no flush pulse after release.

Structure
REQ-029 Stall-vector constants, FSM state encodings, EXC_VECTOR and ERET_CODE SHALL live in the shared CPU defines package.
REQ-030 Single module; no sub-module (the saturating counter stays inline).

Verification
REQ-031 Priority: stallreq_mem=1, stallreq_id=1, stallreq_if=1 -> stall=6'b011111; drop mem -> 6'b000111; drop id -> 6'b000011.
REQ-032 Exception: IDLE, excepttype_i=32'h00000008 one cycle -> that cycle stall=6'b111111; next cycle flush=1, new_pc=32'h00000020; following cycle flush=0, busy=0.
REQ-033 ERET during I-miss: excepttype_i=ERET_CODE, cp0_epc_i=32'h00400100, stallreq_if=1 for 3 cycles -> stall=6'b111111, busy=1 for 4 cycles; cycle after stallreq_if falls flush=1, new_pc=32'h00400100; epc changes in WAIT_IF do not alter new_pc.
REQ-034 Counter: stallreq_ex=1 for 70000 cycles -> stall_cnt=16'hFFFF held; clr_cnt=1 with stallreq_ex=1 -> stall_cnt=0 next cycle.
REQ-035 Reset mid-sequence: enter WAIT_IF, assert rst asynchronously -> state IDLE, busy=0 immediately; release with stallreq_if=0 -> no flush pulse.
